// File: rtl/reg_select_encoder.sv
// reg_select_encoder: turns pending one-hot/multi-hot register requests into 4-bit indices.
// Latency: one cycle from req to idx_valid; back-to-back grants while idx_ready stays high.
// Backpressure: idx/multi hold while idx_valid && !idx_ready; new requests accumulate in pending.
// Optional build macro: REG_SELECT_ROUND_ROBIN_EN (round-robin selection instead of lowest index first).
// Bit mapping: register index i <-> vector bit (15 - i).
module reg_select_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        clr,
   output logic [3:0]  idx,
   output logic        idx_valid,
   input  logic        idx_ready,
   output logic        multi,
   output logic [15:0] pending
);

   typedef enum logic {S_IDLE = 1'b0, S_PRESENT = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_pending;
   logic [3:0]  r_idx;
   logic        r_multi;

   logic [15:0] w_cand;
   logic [15:0] w_sel_mask;
   logic [15:0] w_pend_nxt;
   logic [3:0]  w_sel;
   logic [3:0]  w_ptr;
   logic        w_any;
   logic        w_multi;
   logic        w_hs;
   logic        w_load;

`ifdef REG_SELECT_ROUND_ROBIN_EN
   logic [3:0]  r_ptr;

   // Round-robin pointer: next search starts just past the last granted index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 4'd0;
      end else if (w_load) begin
         r_ptr <= w_sel + 4'd1;
      end
   end

   assign w_ptr = r_ptr;
`else
   // Fixed priority is an upward search that always starts at index 0.
   assign w_ptr = 4'd0;
`endif

   // Candidates: clr discards both the pending vector and this cycle's requests.
   assign w_cand = clr ? 16'h0000 : (r_pending | req);
   assign w_any  = |w_cand;
   // Two or more bits set iff clearing the lowest set bit leaves something behind.
   assign w_multi = |(w_cand & (w_cand - 16'd1));

   assign w_hs   = (r_state == S_PRESENT) && idx_ready;
   assign w_load = w_any && ((r_state == S_IDLE) || w_hs);

   // Select the first candidate found searching upward from the pointer, wrapping 15 -> 0.
   always_comb begin
      logic [3:0] v_j;
      w_sel = 4'd0;
      v_j   = 4'd0;
      for (int k = 15; k >= 0; k--) begin
         v_j = w_ptr + 4'(k);
         if (w_cand[4'd15 - v_j]) begin
            w_sel = v_j;
         end
      end
   end

   assign w_sel_mask = 16'h8000 >> w_sel;
   // The granted bit leaves the pending vector; everything else is retained.
   assign w_pend_nxt = w_load ? (w_cand & ~w_sel_mask) : w_cand;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: leave PRESENT only on a handshake with nothing left to grant.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_any) w_state_nxt = S_PRESENT;
         S_PRESENT: if (w_hs && !w_any) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Grant and pending registers; idx/multi hold their last value when not reloaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx     <= 4'd0;
         r_multi   <= 1'b0;
         r_pending <= 16'h0000;
      end else begin
         r_pending <= w_pend_nxt;
         if (w_load) begin
            r_idx   <= w_sel;
            r_multi <= w_multi;
         end
      end
   end

   // Outputs are driven directly from registers only.
   always_comb begin
      idx       = r_idx;
      multi     = r_multi;
      pending   = r_pending;
      idx_valid = (r_state == S_PRESENT);
   end

endmodule

// File: doc/reg_select_encoder.md
# reg_select_encoder

Converts 16 per-register request lines into a stream of 4-bit register indices for the shared register-file port. It is the inverse of the register decoder: the decoder turns a 4-bit code into a one-hot enable, and this block turns pending one-hot/multi-hot requests back into codes. Requests are accumulated in a pending vector and granted one at a time over a valid/ready handshake, so requests are never lost while the consumer is stalled.

## Interface
- Parameters: none. The width is fixed at 16 sources and a 4-bit index.
- Bit mapping, identical to the decoder: register index i ↔ vector bit (15 − i). Index 0 is bit 15; index 15 is bit 0.
- `clk`  in  1  Sole clock. All state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `req`  in  16  Request lines, sampled every edge. A high bit requests service of that register. Level or pulse; one sample is enough.
- `clr`  in  1  Synchronous clear of all pending (un-granted) requests.
- `idx`  out  4  Granted register index. Registered.
- `idx_valid`  out  1  `idx` holds a grant awaiting acceptance.
- `idx_ready`  in  1  Consumer accepts `idx` on an edge where `idx_valid` and `idx_ready` are both 1.
- `multi`  out  1  Registered alongside `idx`. 1 if two or more candidates existed when this grant was made.
- `pending`  out  16  Registered vector of requests not yet granted. The in-flight grant is excluded.

## Operation
- `cand = pending | req`, computed combinationally.
- `sel(cand)` picks one set bit. Default policy: lowest index first, i.e. the highest set vector bit.
- States:
  - **IDLE**: `idx_valid` = 0.
  - **PRESENT**: `idx_valid` = 1.
- IDLE, `cand` ≠ 0: on the edge, `idx` ← `sel(cand)`, `multi` ← (popcount(`cand`) ≥ 2), `pending` ← `cand` with the selected bit cleared, go to PRESENT.
- IDLE, `cand` = 0: stay in IDLE; `pending` stays 0.
- PRESENT, no handshake: `idx` and `multi` hold stable; `pending` ← `cand`.
- PRESENT, handshake, `cand` ≠ 0: load the next grant exactly as from IDLE; stay in PRESENT. This gives back-to-back grants with no bubble.
- PRESENT, handshake, `cand` = 0: go to IDLE; `idx_valid` ← 0; `idx` holds its last value.
- A `req` for the index currently in flight sets its `pending` bit. That register is granted again later; the request is not merged.
- `clr` = 1: `pending` ← 0, and `req` in the same cycle is discarded (`clr` wins).
  - An in-flight grant is not aborted; it completes normally on handshake.
  - A `clr` in IDLE blocks any grant that edge.
- `idx_valid` never drops without a handshake, except on reset.

## Timing
- Latency: `req` bit high before edge k with the block in IDLE → `idx_valid` = 1 with the matching `idx` after edge k (one cycle).
- Throughput: one grant per cycle while `idx_ready` is held at 1 and `cand` ≠ 0.
- Reset values:
  - `idx` = 0, `idx_valid` = 0, `multi` = 0, `pending` = 0.
  - State = IDLE; round-robin pointer = 0.
- Reset asserted mid-handshake drops the grant and all pending requests immediately (asynchronously).
- First grant possible after edge k, where k is the first edge with `rst_n` high.
- All outputs come straight from registers; there is no combinational path from `req` or `idx_ready` to any output.

## Configuration
- Macro: `REG_SELECT_ROUND_ROBIN_EN`.
- Defined: `sel` searches upward from pointer `p` and wraps 15→0.
  - On every grant, `p` ← granted index + 1, modulo 16.
  - No source waits more than 15 grants.
- Undefined: fixed priority, lowest index first. No pointer register is built.

## Test plan
- Reset, then `req` = 16'h8000 for one cycle → after the next edge `idx` = 0, `idx_valid` = 1, `multi` = 0, `pending` = 0. With `idx_ready` = 1, the block returns to IDLE.
- `req` = 16'h0021 for one cycle, `idx_ready` held at 1, fixed priority → `idx` = 10 with `multi` = 1, then `idx` = 15 with `multi` = 0 on consecutive cycles, then `idx_valid` = 0.
- `req` = 16'hFFFF pulse, `idx_ready` = 0 for 5 cycles, then 1 → `idx` holds 0 for 6 cycles, `pending` = 16'h7FFF, then indices 1..15 follow back-to-back.
- With `REG_SELECT_ROUND_ROBIN_EN`: grant index 3, then `req` = 16'h9001 (indices 0, 3, 15) → grant order 15, 0, 3.
- `idx` = 5 in flight, stalled; pulse `req` = 16'h0400 (index 5) and assert `clr` on the following cycle → `pending` = 0, index 5 completes once, and no re-grant occurs.
- `rst_n` low while `idx_valid` = 1 and `pending` = 16'h00F0 → all outputs go to 0 asynchronously, and no grant appears after `rst_n` is released until a new `req`.
